// File: rtl/mux4_rr_arb.sv
// mux4_rr_arb: four-requester round-robin arbiter/mux feeding a single
// registered output slot with valid/ready handshake.
//
// Ports
//   i_clk    clock, all state updates on rising edge
//   i_rst    synchronous active-high reset
//   i_req    [3:0] per-requester valid beat
//   i_data   [4*DATA_W-1:0] requester k data at [k*DATA_W +: DATA_W]
//   i_last   [3:0] per-requester end-of-packet marker
//   o_ack    [3:0] one-hot combinational accept strobe to the winner
//   i_ready  downstream can take the beat on the output
//   o_valid  output register holds a beat
//   o_data   [DATA_W-1:0] registered beat
//   o_sel    [1:0] index of requester that sourced o_data
//   o_last   registered copy of the winner's i_last
//
// Build option
//   MUX4_RR_ARB_LOCK_EN  when defined, a packet (beats up to i_last=1) from
//                        one requester is never interleaved with others.
//
// Output FSM
//   state | meaning
//   EMPTY | output slot holds no beat (o_valid=0)
//   FULL  | output slot holds a beat waiting for / being taken by i_ready

module mux4_rr_arb #(
    parameter int DATA_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [3:0]            i_req,
    input  logic [4*DATA_W-1:0]   i_data,
    input  logic [3:0]            i_last,
    output logic [3:0]            o_ack,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_W-1:0]     o_data,
    output logic [1:0]            o_sel,
    output logic                  o_last
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  ptr;
    logic [3:0]  elig;
    logic        load;
    logic        found;
    logic [1:0]  win;
    logic        accept;
    logic        win_last;

`ifdef MUX4_RR_ARB_LOCK_EN
    logic        locked;
    logic [1:0]  lock_idx;

    // While locked only the packet owner may win.
    always_comb begin
        elig = i_req;
        if (locked) begin
            elig = i_req & (4'b0001 << lock_idx);
        end
    end
`else
    always_comb begin
        elig = i_req;
    end
`endif

    assign o_valid = (state == FULL);
    assign load    = !o_valid || i_ready;

    // Circular scan starting at ptr; first eligible requester wins.
    always_comb begin
        logic [1:0] idx;
        found = 1'b0;
        win   = 2'd0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Reset suppresses the strobe so a requester never believes a beat was
    // taken that the reset is about to discard.
    assign accept   = load && found && !i_rst;
    assign o_ack    = accept ? (4'b0001 << win) : 4'b0000;
    assign win_last = i_last[win];

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_nxt = FULL;
                end else if (i_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data <= '0;
            o_sel  <= 2'd0;
            o_last <= 1'b0;
        end else if (accept) begin
            o_data <= i_data[32'(win)*DATA_W +: DATA_W];
            o_sel  <= win;
            o_last <= win_last;
        end
    end

`ifdef MUX4_RR_ARB_LOCK_EN
    // ptr stays put for the whole packet and moves past the owner only when
    // its final beat is accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr      <= 2'd0;
            locked   <= 1'b0;
            lock_idx <= 2'd0;
        end else if (accept) begin
            if (win_last) begin
                locked <= 1'b0;
                ptr    <= win + 2'd1;
            end else begin
                locked   <= 1'b1;
                lock_idx <= win;
            end
        end
    end
`else
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr <= 2'd0;
        end else if (accept) begin
            ptr <= win + 2'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mux4_rr_arb.sv
module tb_mux4_rr_arb;

    localparam int DATA_W = 8;

    logic                clk;
    logic                rst;
    logic [3:0]          req;
    logic [4*DATA_W-1:0] data;
    logic [3:0]          last;
    logic [3:0]          ack;
    logic                ready;
    logic                valid;
    logic [DATA_W-1:0]   odata;
    logic [1:0]          sel;
    logic                olast;

    int total = 0;
    int bad   = 0;

    mux4_rr_arb #(.DATA_W(DATA_W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req),
        .i_data  (data),
        .i_last  (last),
        .o_ack   (ack),
        .i_ready (ready),
        .o_valid (valid),
        .o_data  (odata),
        .o_sel   (sel),
        .o_last  (olast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  last;
        logic        ready;
        logic [31:0] data;
        logic [3:0]  e_ack;
        logic        e_valid;
        logic [1:0]  e_sel;
        logic [7:0]  e_data;
        logic        e_last;
    } vec_t;

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, sample mid-cycle:
    // o_ack reflects this cycle, registered outputs reflect prior edges.
    task automatic apply(input logic r, input logic [3:0] q, input logic [3:0] l,
                         input logic rdy, input logic [31:0] d);
        @(posedge clk);
        #1;
        rst   = r;
        req   = q;
        last  = l;
        ready = rdy;
        data  = d;
        #4;
    endtask

    task automatic chk_all(input int row, input logic [3:0] e_ack, input logic e_valid,
                           input logic [1:0] e_sel, input logic [7:0] e_data,
                           input logic e_last);
        chk("ack",   row, 32'(ack),   32'(e_ack));
        chk("valid", row, 32'(valid), 32'(e_valid));
        chk("sel",   row, 32'(sel),   32'(e_sel));
        chk("data",  row, 32'(odata), 32'(e_data));
        chk("last",  row, 32'(olast), 32'(e_last));
    endtask

    localparam logic [31:0] D  = 32'hD3C2B1A0;
    localparam logic [31:0] DA = 32'hD3A5B1A0;

    vec_t vecs[20];

    initial begin
        rst = 1'b1; req = '0; last = '0; ready = 1'b0; data = '0;

        //          rst  req      last     rdy  data  ack      v    sel   data   last
        vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 1'b1, D,  4'b0000, 1'b0, 2'd0, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, D,  4'b0001, 1'b0, 2'd0, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 4'b1111, 4'b0010, 1'b1, D,  4'b0010, 1'b1, 2'd0, 8'hA0, 1'b0};
        vecs[3]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, D,  4'b0100, 1'b1, 2'd1, 8'hB1, 1'b1};
        vecs[4]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, D,  4'b1000, 1'b1, 2'd2, 8'hC2, 1'b0};
        vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, D,  4'b0000, 1'b1, 2'd3, 8'hD3, 1'b0};
        vecs[6]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, D,  4'b0000, 1'b0, 2'd3, 8'hD3, 1'b0};
        vecs[7]  = '{1'b0, 4'b0100, 4'b0000, 1'b1, D,  4'b0100, 1'b0, 2'd3, 8'hD3, 1'b0};
        vecs[8]  = '{1'b0, 4'b1001, 4'b0000, 1'b1, D,  4'b1000, 1'b1, 2'd2, 8'hC2, 1'b0};
        vecs[9]  = '{1'b0, 4'b1001, 4'b0000, 1'b1, D,  4'b0001, 1'b1, 2'd3, 8'hD3, 1'b0};
        vecs[10] = '{1'b0, 4'b0000, 4'b0000, 1'b0, D,  4'b0000, 1'b1, 2'd0, 8'hA0, 1'b0};
        vecs[11] = '{1'b0, 4'b0100, 4'b0000, 1'b0, D,  4'b0000, 1'b1, 2'd0, 8'hA0, 1'b0};
        vecs[12] = '{1'b0, 4'b0100, 4'b0000, 1'b0, D,  4'b0000, 1'b1, 2'd0, 8'hA0, 1'b0};
        vecs[13] = '{1'b0, 4'b0100, 4'b0000, 1'b0, D,  4'b0000, 1'b1, 2'd0, 8'hA0, 1'b0};
        vecs[14] = '{1'b0, 4'b0100, 4'b0000, 1'b1, DA, 4'b0100, 1'b1, 2'd0, 8'hA0, 1'b0};
        vecs[15] = '{1'b0, 4'b0000, 4'b0000, 1'b0, DA, 4'b0000, 1'b1, 2'd2, 8'hA5, 1'b0};
        vecs[16] = '{1'b1, 4'b1111, 4'b0000, 1'b0, DA, 4'b0000, 1'b1, 2'd2, 8'hA5, 1'b0};
        vecs[17] = '{1'b0, 4'b1111, 4'b0001, 1'b1, D,  4'b0001, 1'b0, 2'd0, 8'h00, 1'b0};
        vecs[18] = '{1'b0, 4'b0000, 4'b0000, 1'b1, D,  4'b0000, 1'b1, 2'd0, 8'hA0, 1'b1};
        vecs[19] = '{1'b0, 4'b0000, 4'b0000, 1'b1, D,  4'b0000, 1'b0, 2'd0, 8'hA0, 1'b1};

        apply(1'b1, 4'b0000, 4'b0000, 1'b0, D);
        apply(1'b1, 4'b0000, 4'b0000, 1'b0, D);

`ifndef MUX4_RR_ARB_LOCK_EN
        for (int k = 0; k < 20; k++) begin
            apply(vecs[k].rst, vecs[k].req, vecs[k].last, vecs[k].ready, vecs[k].data);
            chk_all(k, vecs[k].e_ack, vecs[k].e_valid, vecs[k].e_sel,
                    vecs[k].e_data, vecs[k].e_last);
        end

        // A lone requester streams one beat per cycle with the slot kept full.
        apply(1'b1, 4'b0000, 4'b0000, 1'b1, D);
        apply(1'b0, 4'b0010, 4'b0000, 1'b1, D);
        chk_all(100, 4'b0010, 1'b0, 2'd0, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 4'b0010, 4'b0000, 1'b1, D);
            chk_all(101 + k, 4'b0010, 1'b1, 2'd1, 8'hB1, 1'b0);
        end
`else
        // Requester 1 single-beat packet moves ptr to 2.
        apply(1'b0, 4'b0010, 4'b0010, 1'b1, D);
        chk_all(200, 4'b0010, 1'b0, 2'd0, 8'h00, 1'b0);
        // Requester 2 three-beat packet against full contention.
        apply(1'b0, 4'b1111, 4'b0000, 1'b1, D);
        chk_all(201, 4'b0100, 1'b1, 2'd1, 8'hB1, 1'b1);
        apply(1'b0, 4'b1111, 4'b0000, 1'b1, D);
        chk_all(202, 4'b0100, 1'b1, 2'd2, 8'hC2, 1'b0);
        apply(1'b0, 4'b1111, 4'b0100, 1'b1, D);
        chk_all(203, 4'b0100, 1'b1, 2'd2, 8'hC2, 1'b0);
        apply(1'b0, 4'b1111, 4'b0000, 1'b1, D);
        chk_all(204, 4'b1000, 1'b1, 2'd2, 8'hC2, 1'b1);
        apply(1'b0, 4'b0000, 4'b0000, 1'b1, D);
        chk_all(205, 4'b0000, 1'b1, 2'd3, 8'hD3, 1'b0);
        // Locked to 3 now; others are ignored until its last beat.
        apply(1'b0, 4'b0111, 4'b0000, 1'b1, D);
        chk_all(206, 4'b0000, 1'b0, 2'd3, 8'hD3, 1'b0);
        apply(1'b0, 4'b1111, 4'b1000, 1'b1, D);
        chk_all(207, 4'b1000, 1'b0, 2'd3, 8'hD3, 1'b0);
        apply(1'b0, 4'b1111, 4'b1111, 1'b1, D);
        chk_all(208, 4'b0001, 1'b1, 2'd3, 8'hD3, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mux4_rr_arb.md
MUX4_RR_ARB -- requirements
Module: mux4_rr_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of each requester's data word.
REQ-002 SHALL have port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1: reset, synchronous to i_clk and active-high.
REQ-004 SHALL have port i_req, input, 4: bit k set means requester k presents a valid beat.
REQ-005 SHALL have port i_data, input, 4*DATA_W: requester k's word at bits [k*DATA_W +: DATA_W].
REQ-006 SHALL have port i_last, input, 4: bit k marks requester k's beat as the last of its packet.
REQ-007 SHALL have port o_ack, output, 4: one-hot combinational accept strobe to the winning requester.
REQ-008 SHALL have port i_ready, input, 1: downstream can take the beat held on the output.
REQ-009 SHALL have port o_valid, output, 1: the output register holds a beat.
REQ-010 SHALL have port o_data, output, DATA_W: the registered beat.
REQ-011 SHALL have port o_sel, output, 2: index of the requester that sourced o_data.
REQ-012 SHALL have port o_last, output, 1: registered copy of the winner's i_last.

Function
REQ-013 SHALL define load = !o_valid | i_ready, meaning the output slot is empty or is being drained this cycle.
REQ-014 SHALL, when load=1 and i_req!=0, pick as winner the first set bit of i_req, scanning circularly from priority pointer ptr (ptr, ptr+1, ... mod 4).
REQ-015 SHALL assert o_ack[winner] in that same cycle; o_ack SHALL be 4'b0000 when load=0 or i_req=0.
REQ-016 SHALL, on the following edge, register o_data<=i_data[winner], o_sel<=winner, o_last<=i_last[winner], o_valid<=1 (1-cycle latency from acceptance to output).
REQ-017 SHALL update ptr<=(winner+1) mod 4 on every accepted beat, wrapping 3->0.
REQ-018 SHALL clear o_valid on the next edge when load=1 and i_req=0.
REQ-019 SHALL hold o_data, o_sel, o_last and o_valid unchanged while o_valid=1 and i_ready=0.
REQ-020 SHALL sustain one beat per cycle while i_ready=1 and requests are pending.
REQ-021 SHALL implement a 2-state output FSM: EMPTY (o_valid=0) goes to FULL on an accept; FULL stays FULL on an accept or a stall; FULL goes to EMPTY when i_ready=1 and there is no accept.
REQ-022 SHALL tolerate a requester dropping i_req before it is acked: that beat is not transferred and nothing else changes.

Reset
REQ-023 SHALL, while i_rst=1 at the clock edge, force o_valid=0, o_data=0, o_sel=0, o_last=0, ptr=0, state EMPTY and lock cleared; reset takes priority over any simultaneous accept.
REQ-024 SHALL drive o_ack=0 during any cycle in which i_rst=1.
REQ-025 SHALL discard a beat held in the output register when reset is asserted mid-stall; the beat is not replayed.

Configuration
REQ-026 SHALL support macro MUX4_RR_ARB_LOCK_EN.
- Defined: after accepting a beat with i_last=0, the arbiter SHALL lock to that requester.
- While locked, only that requester is eligible and ptr is frozen.
- The lock SHALL release, and ptr SHALL advance, when that requester's beat with i_last=1 is accepted.
REQ-027 SHALL, without MUX4_RR_ARB_LOCK_EN, re-arbitrate on every beat; i_last then only feeds o_last.

Verification
REQ-028 SHALL cover: reset, then i_req=4'b1111 and i_ready=1 for 4 cycles -> o_ack sequence 0001, 0010, 0100, 1000; o_sel 0,1,2,3 one cycle later.
REQ-029 SHALL cover: ptr=3 with i_req=4'b1001 -> o_ack=1000 then 0001 (wrap-around).
REQ-030 SHALL cover: o_valid=1, i_ready=0 for 3 cycles with i_req=4'b0100 -> o_ack=0, o_data/o_sel held; i_ready=1 -> o_ack=0100 the same cycle.
REQ-031 SHALL cover: i_req=0 with i_ready=1 while FULL -> o_valid=0 next cycle, o_ack=0.
REQ-032 SHALL cover, with MUX4_RR_ARB_LOCK_EN: requester 2 sends a 3-beat packet (i_last 0,0,1) while i_req=4'b1111 -> o_sel=2,2,2, then o_sel=3.
REQ-033 SHALL cover: i_rst=1 mid-stall with o_valid=1 and data 8'hA5 -> next cycle o_valid=0, o_data=0, and first grant goes to requester 0.
